lab4_branch_resolve_queue: RTL and testbench
============================================

Name: lab4_branch_resolve_queue

Overview:
- In-order queue between fetch and the branch resolution stage; drives the update side of the bimodal predictor (update_en / update_val / PC).
- Fetch enqueues each predicted branch (PC, predicted direction). Execute resolves branches oldest-first.
- On each resolution the block emits a one-cycle predictor update and flags a mispredict.
- On a mispredict it flushes all younger, wrong-path entries.

Parameters:
- p_depth, 4, queue entries; power of two, at least 2.
- p_pc_nbits, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- pred_val  in  1  fetch presents a predicted branch.
- pred_rdy  out  1  queue can accept; = !full.
- pred_pc  in  p_pc_nbits  PC of predicted branch.
- pred_taken  in  1  direction predicted by the predictor.
- resolve_val  in  1  execute resolves the oldest branch.
- resolve_rdy  out  1  = !empty.
- resolve_taken  in  1  actual branch outcome.
- squash  in  1  external flush (e.g. exception); clears all entries.
- update_en  out  1  registered one-cycle pulse to the predictor.
- update_val  out  1  actual outcome for the update.
- update_pc  out  p_pc_nbits  PC for the update.
- mispredict  out  1  registered; valid when update_en=1.
- count  out  $clog2(p_depth)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail and count cleared to 0.
  - update_en=0, update_val=0, update_pc=0, mispredict=0.
  - Entry contents are don't-care.
- Enqueue fires when pred_val && pred_rdy: entry {pred_pc, pred_taken} written at tail; tail increments modulo p_depth.
- Resolve fires when resolve_val && resolve_rdy. On the next posedge, head advances modulo p_depth, and the cycle after the fire edge shows:
  - update_en=1
  - update_pc = head.pc
  - update_val = resolve_taken
  - mispredict = (resolve_taken != head.taken)
- Latency: exactly 1 cycle from resolve fire to update_en. update_en is high for exactly one cycle per fire. Back-to-back fires give back-to-back pulses.
- Without a fire, update_en=0 and mispredict=0. update_pc and update_val hold their last values.
- Mispredicting resolve:
  - The head's update is still produced.
  - All remaining entries are discarded at the same edge: head=tail, count=0.
  - Any enqueue firing in that same cycle is dropped (wrong path).
- squash=1 at a posedge: all entries discarded, count=0, and any same-cycle enqueue is dropped.
- squash together with a resolve fire: the update for the head is still emitted; the queue is then empty.
- Full (count==p_depth): pred_rdy=0. There is no bypass; an enqueue is not accepted even if a resolve fires in the same cycle.
- Empty (count==0): resolve_rdy=0, and a resolve_val is ignored.
- Simultaneous correct-prediction resolve and enqueue when not full: both occur; count is unchanged.
- Pointer wrap: p_depth enqueues return tail to 0. The FIFO order must survive wrap.
- count = enqueues − dequeues, saturating only by the handshake rules; it never exceeds p_depth.
- pred_rdy and resolve_rdy are combinational from count only; they do not depend on pred_val or resolve_val.

Decomposition:
- Shared package lab4_branch_pkg holds:
  - typedef resolve_entry_t {logic [p_pc_nbits-1:0] pc; logic taken;}
  - constant for the default depth.
- One sub-module, lab4_branch_resolve_queue_storage:
  - p_depth x entry register array.
  - One synchronous write port (tail) and one combinational read port (head).
  - No reset on contents.
- The control logic (pointers, count, flush, output registers) stays in the top module.

Test Plan:
- Reset, then enqueue PC=0x20C taken=0 and resolve with taken=1 → next cycle update_en=1, update_pc=0x20C, update_val=1, mispredict=1; count=0.
- Enqueue 4 entries (PCs 0x100, 0x104, 0x108, 0x10C, all taken=1) → pred_rdy=0 and count=4. Four back-to-back correct resolves (taken=1) → four consecutive update_en pulses with PCs in order 0x100..0x10C, mispredict=0; the fifth cycle has update_en=0.
- Wrap: interleave 10 enqueues and 10 correct resolves keeping count ≤3 → update_pc sequence exactly matches the enqueue order.
- Mispredict flush: enqueue 0x200(T), 0x204(T), 0x208(N); resolve head with taken=0, with a same-cycle enqueue of 0x20C → update 0x200 mispredict=1; count=0, resolve_rdy=0, and 0x20C is not queued.
- Squash and reset: with 3 entries queued, squash=1 for one cycle → count=0 and no update_en. Enqueue 2 entries, then drop reset low asynchronously mid-cycle → count=0 and update_en=0 immediately, before the next clock edge.
- Empty/full edges:
  - resolve_val=1 while empty → no update_en, count stays 0.
  - pred_val=1 while full with a correct resolve in the same cycle → count goes 4 to 3 and the new entry is not written.

Source files
------------

// File: rtl/lab4_branch_pkg.sv
// Shared definitions for the branch resolve queue.
//   DEFAULT_DEPTH    : default number of in-flight predicted branches
//   DEFAULT_PC_NBITS : default PC width
//   resolve_entry_t  : one queued branch {pc, predicted direction}
package lab4_branch_pkg;

  localparam int DEFAULT_DEPTH    = 4;
  localparam int DEFAULT_PC_NBITS = 32;

  typedef struct packed {
    logic [DEFAULT_PC_NBITS-1:0] pc;
    logic                        taken;
  } resolve_entry_t;

endpackage

// File: rtl/lab4_branch_resolve_queue_storage.sv
// Entry array for the branch resolve queue.
//   clk_i   : clock
//   we_i    : write strobe, writes wdata_i at waddr_i on posedge
//   waddr_i : write index (tail)
//   wdata_i : packed {pc, taken}
//   raddr_i : read index (head)
//   rdata_o : combinational read of entry at raddr_i
// Contents are not reset; the control logic never reads an entry it has not written.
module lab4_branch_resolve_queue_storage #(
  parameter int p_depth = 4,
  parameter int p_width = 33
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(p_depth)-1:0] waddr_i,
  input  logic [p_width-1:0]         wdata_i,
  input  logic [$clog2(p_depth)-1:0] raddr_i,
  output logic [p_width-1:0]         rdata_o
);

  logic [p_width-1:0] mem_q [p_depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lab4_branch_resolve_queue.sv
// In-order queue of predicted branches between fetch and branch resolution.
// Each resolve of the oldest entry produces a registered one-cycle predictor
// update (update_en_o/update_val_o/update_pc_o) and a mispredict flag. A
// mispredict or an external squash discards every queued entry and any
// enqueue in the same cycle.
//   clk_i, reset_ni              : clock, async active-low reset
//   pred_val_i/pred_rdy_o        : enqueue handshake, pred_pc_i/pred_taken_i payload
//   resolve_val_i/resolve_rdy_o  : resolve handshake, resolve_taken_i actual outcome
//   squash_i                     : external flush
//   update_en_o/val_o/pc_o       : predictor update, mispredict_o valid with update_en_o
//   count_o                      : occupancy
module lab4_branch_resolve_queue
  import lab4_branch_pkg::*;
#(
  parameter int p_depth    = DEFAULT_DEPTH,
  parameter int p_pc_nbits = DEFAULT_PC_NBITS
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       pred_val_i,
  output logic                       pred_rdy_o,
  input  logic [p_pc_nbits-1:0]      pred_pc_i,
  input  logic                       pred_taken_i,
  input  logic                       resolve_val_i,
  output logic                       resolve_rdy_o,
  input  logic                       resolve_taken_i,
  input  logic                       squash_i,
  output logic                       update_en_o,
  output logic                       update_val_o,
  output logic [p_pc_nbits-1:0]      update_pc_o,
  output logic                       mispredict_o,
  output logic [$clog2(p_depth):0]   count_o
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = AW + 1;

  logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  upd_en_q, upd_val_q, mis_q;
  logic [p_pc_nbits-1:0] upd_pc_q;

  logic                  full, empty, enq_fire, deq_fire, mis_now, flush, wr_en;
  logic [p_pc_nbits:0]   rd_data;
  logic [p_pc_nbits-1:0] head_pc;
  logic                  head_taken;

  assign full          = (count_q == CW'(p_depth));
  assign empty         = (count_q == '0);
  assign pred_rdy_o    = !full;
  assign resolve_rdy_o = !empty;

  assign enq_fire   = pred_val_i && !full;
  assign deq_fire   = resolve_val_i && !empty;
  assign head_pc    = rd_data[p_pc_nbits:1];
  assign head_taken = rd_data[0];
  assign mis_now    = deq_fire && (resolve_taken_i != head_taken);
  // Anything fetched behind a mispredicted or squashed branch is wrong-path.
  assign flush      = squash_i || mis_now;
  assign wr_en      = enq_fire && !flush;

  lab4_branch_resolve_queue_storage #(
    .p_depth (p_depth),
    .p_width (p_pc_nbits + 1)
  ) u_storage (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (tail_q),
    .wdata_i ({pred_pc_i, pred_taken_i}),
    .raddr_i (head_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Collapse to empty without touching tail: head catches up to it.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (deq_fire) head_d = head_q + AW'(1);
      if (enq_fire) tail_d = tail_q + AW'(1);
      count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      upd_en_q  <= 1'b0;
      upd_val_q <= 1'b0;
      upd_pc_q  <= '0;
      mis_q     <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      upd_en_q <= deq_fire;
      mis_q    <= mis_now;
      // pc/val hold their last update between fires.
      if (deq_fire) begin
        upd_pc_q  <= head_pc;
        upd_val_q <= resolve_taken_i;
      end
    end
  end

  assign update_en_o  = upd_en_q;
  assign update_val_o = upd_val_q;
  assign update_pc_o  = upd_pc_q;
  assign mispredict_o = mis_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_lab4_branch_resolve_queue.sv
module tb_lab4_branch_resolve_queue;
  import lab4_branch_pkg::*;

  localparam int D  = 4;
  localparam int PW = 32;

  typedef struct packed {
    resolve_entry_t e;   // e.taken carries the expected update_val
    logic           mis;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pred_val = 1'b0, pred_taken = 1'b0;
  logic [PW-1:0] pred_pc = '0;
  logic          resolve_val = 1'b0, resolve_taken = 1'b0, squash = 1'b0;
  logic          pred_rdy, resolve_rdy, update_en, update_val, mispredict;
  logic [PW-1:0] update_pc;
  logic [2:0]    count;

  int n_cmp = 0;
  int n_mis = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  lab4_branch_resolve_queue #(.p_depth(D), .p_pc_nbits(PW)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .pred_val_i(pred_val), .pred_rdy_o(pred_rdy), .pred_pc_i(pred_pc),
    .pred_taken_i(pred_taken), .resolve_val_i(resolve_val),
    .resolve_rdy_o(resolve_rdy), .resolve_taken_i(resolve_taken),
    .squash_i(squash), .update_en_o(update_en), .update_val_o(update_val),
    .update_pc_o(update_pc), .mispredict_o(mispredict), .count_o(count)
  );

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every update pulse must match the oldest expected update.
  always @(negedge clk) begin
    if (rst_n) begin
      if (update_en) begin
        if (sb.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL unexpected_update: got pc 0x%0h expected no pulse at %0t", update_pc, $time);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("update_pc", update_pc, x.e.pc);
          chk("update_val", PW'(update_val), PW'(x.e.taken));
          chk("mispredict", PW'(mispredict), PW'(x.mis));
        end
      end else begin
        chk("mispredict_idle", PW'(mispredict), '0);
      end
    end
  end

  // One clock of stimulus; inputs change 1 ns after the edge.
  task automatic cyc(input logic pv, input logic [PW-1:0] pc, input logic pt,
                     input logic rv, input logic rt, input logic sq);
    pred_val = pv; pred_pc = pc; pred_taken = pt;
    resolve_val = rv; resolve_taken = rt; squash = sq;
    @(posedge clk); #1;
    pred_val = 0; resolve_val = 0; squash = 0;
  endtask

  task automatic enq(input logic [PW-1:0] pc, input logic t);
    cyc(1, pc, t, 0, 0, 0);
  endtask

  task automatic expect_upd(input logic [PW-1:0] pc, input logic val, input logic mis);
    exp_t x;
    x.e.pc = pc; x.e.taken = val; x.mis = mis;
    sb.push_back(x);
  endtask

  task automatic res(input logic rt, input logic [PW-1:0] pc, input logic mis);
    expect_upd(pc, rt, mis);
    cyc(0, '0, 0, 1, rt, 0);
  endtask

  task automatic idle();
    cyc(0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", PW'(count), 0);
    chk("rst_update_en", PW'(update_en), 0);
    chk("rst_update_pc", update_pc, 0);
    chk("rst_pred_rdy", PW'(pred_rdy), 1);
    chk("rst_resolve_rdy", PW'(resolve_rdy), 0);
    rst_n = 1;
    idle();

    // Single mispredicted resolve
    enq(32'h20C, 0);
    chk("t1_count1", PW'(count), 1);
    res(1, 32'h20C, 1);
    chk("t1_count0", PW'(count), 0);
    idle();

    // Fill, then four back-to-back correct resolves
    for (int i = 0; i < 4; i++) enq(32'h100 + 4 * i, 1);
    chk("t2_full_count", PW'(count), 4);
    chk("t2_pred_rdy", PW'(pred_rdy), 0);
    for (int i = 0; i < 4; i++) res(1, 32'h100 + 4 * i, 0);
    chk("t2_drained", PW'(count), 0);
    idle();
    idle();

    // Wrap: 10 enqueues interleaved with 10 correct resolves
    enq(32'h300, 0);
    for (int i = 1; i < 10; i++) begin
      logic tk;
      tk = 1'(i - 1);
      expect_upd(32'h300 + 4 * (i - 1), tk, 0);
      cyc(1, 32'h300 + 4 * i, 1'(i), 1, tk, 0);
      chk("t3_count", PW'(count), 1);
    end
    res(1, 32'h300 + 4 * 9, 0);
    chk("t3_count_end", PW'(count), 0);
    idle();

    // Mispredict flush with same-cycle wrong-path enqueue
    enq(32'h200, 1); enq(32'h204, 1); enq(32'h208, 0);
    expect_upd(32'h200, 0, 1);
    cyc(1, 32'h20C, 1, 1, 0, 0);
    chk("t4_count", PW'(count), 0);
    chk("t4_resolve_rdy", PW'(resolve_rdy), 0);
    // Resolve while empty is ignored
    cyc(0, '0, 0, 1, 1, 0);
    chk("t4_empty_count", PW'(count), 0);
    idle();

    // External squash
    enq(32'h700, 1); enq(32'h704, 1); enq(32'h708, 1);
    cyc(0, '0, 0, 0, 0, 1);
    chk("t5_squash_count", PW'(count), 0);
    idle();

    // Enqueue while full with a correct resolve: not accepted
    for (int i = 0; i < 4; i++) enq(32'h400 + 4 * i, 0);
    expect_upd(32'h400, 0, 0);
    cyc(1, 32'h500, 1, 1, 0, 0);
    chk("t6_count3", PW'(count), 3);
    for (int i = 1; i < 4; i++) res(0, 32'h400 + 4 * i, 0);
    chk("t6_count0", PW'(count), 0);
    idle();

    // Squash together with resolve: head update still emitted
    enq(32'h600, 1); enq(32'h604, 1);
    expect_upd(32'h600, 1, 0);
    cyc(0, '0, 0, 1, 1, 1);
    chk("t7_count", PW'(count), 0);
    idle();
    chk("t7_hold_pc", update_pc, 32'h600);
    chk("t7_hold_val", PW'(update_val), 1);

    // Asynchronous reset mid-cycle, right after a resolve fire
    enq(32'h800, 1); enq(32'h804, 1);
    cyc(0, '0, 0, 1, 1, 0);
    #1 rst_n = 0;
    #1;
    chk("t8_async_count", PW'(count), 0);
    chk("t8_async_update_en", PW'(update_en), 0);
    chk("t8_async_update_pc", update_pc, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle();
    idle();

    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL missing_updates: got %0d outstanding expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
